// File: rtl/gpio_irq_ctrl.sv
// gpio_irq_ctrl
//   GPIO interrupt controller. Each input is synchronised, debounced and
//   edge- or level-detected into a pending register. Enabled pending bits
//   raise a registered IRQ with a priority vector (lowest index wins).
//
// Ports
//   CLK        system clock
//   RSTb       asynchronous active-low reset
//   GPIO_IN    asynchronous external inputs [N_INPUTS-1:0]
//   ADDR       register index (0 FILT, 1 ENABLE, 2 RISE, 3 FALL,
//              4 PEND, 5 VEC, 6 LEVEL, 7 reserved)
//   DATA_IN    write data
//   WR / RD    single-cycle write / read strobes
//   DATA_OUT   registered read data
//   IRQ        registered interrupt request
//   IRQ_ACK    single-cycle acknowledge, clears the bit named by IRQ_VEC
//   IRQ_VEC    index of highest-priority enabled pending input
module gpio_irq_ctrl #(
  parameter int N_INPUTS        = 6,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                CLK,
  input  logic                RSTb,
  input  logic [N_INPUTS-1:0] GPIO_IN,
  input  logic [2:0]          ADDR,
  input  logic [15:0]         DATA_IN,
  input  logic                WR,
  input  logic                RD,
  output logic [15:0]         DATA_OUT,
  output logic                IRQ,
  input  logic                IRQ_ACK,
  output logic [3:0]          IRQ_VEC
);

  localparam logic [2:0] A_FILT   = 3'd0;
  localparam logic [2:0] A_ENABLE = 3'd1;
  localparam logic [2:0] A_RISE   = 3'd2;
  localparam logic [2:0] A_FALL   = 3'd3;
  localparam logic [2:0] A_PEND   = 3'd4;
  localparam logic [2:0] A_VEC    = 3'd5;
  localparam logic [2:0] A_LEVEL  = 3'd6;

  logic [N_INPUTS-1:0] sync_q [SYNC_STAGES];
  logic [N_INPUTS-1:0] sync_last;
  logic [N_INPUTS-1:0] filt;
  logic [N_INPUTS-1:0] filt_prev;
  logic [N_INPUTS-1:0] enable, rise_en, fall_en, level, pend;
  logic [N_INPUTS-1:0] set_evt, w1c_mask, ack_mask, pend_next;
  logic [N_INPUTS-1:0] active;
  logic [15:0]         rd_data;
  logic                unused_data;

  // Upper write-data bits have no backing storage when N_INPUTS < 16.
  assign unused_data = ^DATA_IN;

  function automatic logic [3:0] lowest_idx(input logic [N_INPUTS-1:0] v);
    lowest_idx = 4'd0;
    for (int i = N_INPUTS - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = i[3:0];
    end
  endfunction

  // ---- synchroniser chain ----
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= GPIO_IN;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync_last = sync_q[SYNC_STAGES-1];

  // ---- debounce filter ----
  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign filt = sync_last;
    end else begin : g_debounce
      localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES);
      logic [7:0]          cnt [N_INPUTS];
      logic [N_INPUTS-1:0] filt_q;

      // The counter tallies full cycles of disagreement; once it has seen
      // DEBOUNCE_CYCLES of them the new value is registered on the next
      // edge. Any agreement discards the partial count.
      always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
          filt_q <= '0;
          for (int i = 0; i < N_INPUTS; i++) cnt[i] <= '0;
        end else begin
          for (int i = 0; i < N_INPUTS; i++) begin
            if (sync_last[i] != filt_q[i]) begin
              if (cnt[i] == DEB_LAST) begin
                filt_q[i] <= sync_last[i];
                cnt[i]    <= '0;
              end else begin
                cnt[i] <= cnt[i] + 8'd1;
              end
            end else begin
              cnt[i] <= '0;
            end
          end
        end
      end

      assign filt = filt_q;
    end
  endgenerate

  // ---- pending logic ----
  assign set_evt  = (filt & ~filt_prev & rise_en) | (~filt & filt_prev & fall_en);
  assign w1c_mask = (WR && ADDR == A_PEND) ? DATA_IN[N_INPUTS-1:0] : '0;

  always_comb begin
    ack_mask = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      ack_mask[i] = IRQ_ACK && IRQ && (IRQ_VEC == i[3:0]);
    end
  end

  // Set wins over a coincident clear; level-mode bits simply follow filt.
  assign pend_next = (level & filt) |
                     (~level & ((pend & ~(w1c_mask | ack_mask)) | set_evt));
  assign active    = pend & enable;

  always_comb begin
    rd_data = '0;
    case (ADDR)
      A_FILT:   rd_data[N_INPUTS-1:0] = filt;
      A_ENABLE: rd_data[N_INPUTS-1:0] = enable;
      A_RISE:   rd_data[N_INPUTS-1:0] = rise_en;
      A_FALL:   rd_data[N_INPUTS-1:0] = fall_en;
      A_PEND:   rd_data[N_INPUTS-1:0] = pend;
      A_VEC:    rd_data = {IRQ, 11'b0, IRQ_VEC};
      A_LEVEL:  rd_data[N_INPUTS-1:0] = level;
      default:  rd_data = '0;
    endcase
  end

  // ---- registers and outputs ----
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      filt_prev <= '0;
      enable    <= '0;
      rise_en   <= '0;
      fall_en   <= '0;
      level     <= '0;
      pend      <= '0;
      IRQ       <= 1'b0;
      IRQ_VEC   <= 4'd0;
      DATA_OUT  <= '0;
    end else begin
      filt_prev <= filt;
      pend      <= pend_next;
      IRQ       <= |active;
      IRQ_VEC   <= lowest_idx(active);
      if (RD) DATA_OUT <= rd_data;
      if (WR) begin
        case (ADDR)
          A_ENABLE: enable  <= DATA_IN[N_INPUTS-1:0];
          A_RISE:   rise_en <= DATA_IN[N_INPUTS-1:0];
          A_FALL:   fall_en <= DATA_IN[N_INPUTS-1:0];
          A_LEVEL:  level   <= DATA_IN[N_INPUTS-1:0];
          default:  ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
module tb_gpio_irq_ctrl;

  logic        CLK;
  logic        RSTb;
  logic [5:0]  GPIO_IN;
  logic [2:0]  ADDR;
  logic [15:0] DATA_IN;
  logic        WR;
  logic        RD;
  logic [15:0] DATA_OUT;
  logic        IRQ;
  logic        IRQ_ACK;
  logic [3:0]  IRQ_VEC;

  int total;
  int bad;

  gpio_irq_ctrl #(.N_INPUTS(6), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .CLK(CLK), .RSTb(RSTb), .GPIO_IN(GPIO_IN), .ADDR(ADDR), .DATA_IN(DATA_IN),
    .WR(WR), .RD(RD), .DATA_OUT(DATA_OUT), .IRQ(IRQ), .IRQ_ACK(IRQ_ACK),
    .IRQ_VEC(IRQ_VEC)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic        do_wr;
    logic [2:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_n(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    WR = 1'b1; ADDR = a; DATA_IN = d;
    cyc();
    WR = 1'b0; DATA_IN = '0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] d);
    RD = 1'b1; ADDR = a;
    cyc();
    RD = 1'b0;
    d = DATA_OUT;
  endtask

  task automatic ack();
    IRQ_ACK = 1'b1;
    cyc();
    IRQ_ACK = 1'b0;
  endtask

  task automatic do_reset();
    GPIO_IN = '0;
    RSTb = 1'b0;
    cyc();
    cyc();
    RSTb = 1'b1;
  endtask

  logic [15:0] d;

  initial begin
    total = 0; bad = 0;
    RSTb = 1'b1; GPIO_IN = '0; ADDR = '0; DATA_IN = '0;
    WR = 1'b0; RD = 1'b0; IRQ_ACK = 1'b0;
    #2;

    tbl[0] = '{"enable_mask",  1'b1, 3'd1, 16'hFFFF, 16'h003F};
    tbl[1] = '{"rise_rw",      1'b1, 3'd2, 16'h0015, 16'h0015};
    tbl[2] = '{"fall_upper",   1'b1, 3'd3, 16'hFFC0, 16'h0000};
    tbl[3] = '{"level_rw",     1'b1, 3'd6, 16'h002A, 16'h002A};
    tbl[4] = '{"addr7",        1'b1, 3'd7, 16'hFFFF, 16'h0000};
    tbl[5] = '{"filt_ro",      1'b1, 3'd0, 16'hFFFF, 16'h0000};
    tbl[6] = '{"vec_idle",     1'b0, 3'd5, 16'h0000, 16'h0000};
    tbl[7] = '{"pend_w1c_idle",1'b1, 3'd4, 16'hFFFF, 16'h0000};
    tbl[8] = '{"level_clr",    1'b1, 3'd6, 16'h0000, 16'h0000};
    tbl[9] = '{"enable_clr",   1'b1, 3'd1, 16'h0000, 16'h0000};

    do_reset();
    check("reset_irq", {15'b0, IRQ}, 16'h0);
    check("reset_vec", {12'b0, IRQ_VEC}, 16'h0);
    check("reset_dout", DATA_OUT, 16'h0);

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].do_wr) wr(tbl[i].addr, tbl[i].wdata);
      rd(tbl[i].addr, d);
      check(tbl[i].name, d, tbl[i].exp);
    end

    // Edge-to-IRQ latency: 2 sync + 4 debounce + 3.
    do_reset();
    wr(3'd1, 16'h0001);
    wr(3'd2, 16'h0001);
    GPIO_IN[0] = 1'b1;
    wait_n(8);
    check("lat_irq_early", {15'b0, IRQ}, 16'h0);
    cyc();
    check("lat_irq_on", {15'b0, IRQ}, 16'h1);
    check("lat_vec", {12'b0, IRQ_VEC}, 16'h0);
    rd(3'd4, d);
    check("lat_pend", d, 16'h0001);
    rd(3'd5, d);
    check("lat_vecreg", d, 16'h8000);
    wr(3'd4, 16'h0001);
    cyc();
    check("w1c_irq_off", {15'b0, IRQ}, 16'h0);

    // Short glitch is rejected.
    do_reset();
    wr(3'd1, 16'h0001);
    wr(3'd2, 16'h0001);
    GPIO_IN[0] = 1'b1;
    wait_n(3);
    GPIO_IN[0] = 1'b0;
    wait_n(15);
    rd(3'd0, d);
    check("glitch_filt", d, 16'h0);
    rd(3'd4, d);
    check("glitch_pend", d, 16'h0);
    check("glitch_irq", {15'b0, IRQ}, 16'h0);

    // Priority and acknowledge.
    do_reset();
    wr(3'd1, 16'h0006);
    wr(3'd2, 16'h0006);
    GPIO_IN[2:1] = 2'b11;
    wait_n(12);
    check("prio_irq", {15'b0, IRQ}, 16'h1);
    check("prio_vec1", {12'b0, IRQ_VEC}, 16'h1);
    ack();
    cyc();
    check("ack1_vec2", {12'b0, IRQ_VEC}, 16'h2);
    check("ack1_irq", {15'b0, IRQ}, 16'h1);
    ack();
    cyc();
    check("ack2_irq", {15'b0, IRQ}, 16'h0);
    rd(3'd4, d);
    check("ack2_pend", d, 16'h0);

    // Falling edge with enable gating.
    do_reset();
    wr(3'd3, 16'h0020);
    GPIO_IN[5] = 1'b1;
    wait_n(12);
    rd(3'd4, d);
    check("fall_rise_ignored", d, 16'h0);
    GPIO_IN[5] = 1'b0;
    wait_n(12);
    rd(3'd4, d);
    check("fall_pend", d, 16'h0020);
    check("fall_irq_masked", {15'b0, IRQ}, 16'h0);
    ack();
    rd(3'd4, d);
    check("ack_no_irq", d, 16'h0020);
    wr(3'd1, 16'h0020);
    check("en_irq_same", {15'b0, IRQ}, 16'h0);
    cyc();
    check("en_irq_next", {15'b0, IRQ}, 16'h1);
    wr(3'd4, 16'h0020);
    cyc();
    check("fall_w1c_irq", {15'b0, IRQ}, 16'h0);

    // W1C coincident with a new rising edge: set wins.
    do_reset();
    wr(3'd2, 16'h0001);
    GPIO_IN[0] = 1'b1;
    wait_n(12);
    GPIO_IN[0] = 1'b0;
    wait_n(12);
    rd(3'd4, d);
    check("race_pre_pend", d, 16'h0001);
    GPIO_IN[0] = 1'b1;
    wait_n(7);
    wr(3'd4, 16'h0001);
    rd(3'd4, d);
    check("race_set_wins", d, 16'h0001);

    // Level mode ignores W1C and follows the input.
    do_reset();
    wr(3'd6, 16'h0008);
    GPIO_IN[3] = 1'b1;
    wait_n(12);
    rd(3'd4, d);
    check("level_pend_hi", d, 16'h0008);
    wr(3'd4, 16'h0008);
    rd(3'd4, d);
    check("level_w1c_noeff", d, 16'h0008);
    GPIO_IN[3] = 1'b0;
    wait_n(12);
    rd(3'd4, d);
    check("level_pend_lo", d, 16'h0);

    // Both-edge detection.
    do_reset();
    wr(3'd2, 16'h0010);
    wr(3'd3, 16'h0010);
    GPIO_IN[4] = 1'b1;
    wait_n(12);
    rd(3'd4, d);
    check("both_rise", d, 16'h0010);
    wr(3'd4, 16'h0010);
    rd(3'd4, d);
    check("both_cleared", d, 16'h0);
    GPIO_IN[4] = 1'b0;
    wait_n(12);
    rd(3'd4, d);
    check("both_fall", d, 16'h0010);

    // Simultaneous WR and RD returns the old value; DATA_OUT holds.
    WR = 1'b1; RD = 1'b1; ADDR = 3'd1; DATA_IN = 16'h0005;
    cyc();
    WR = 1'b0; RD = 1'b0; DATA_IN = '0;
    check("wrrd_old", DATA_OUT, 16'h0);
    rd(3'd1, d);
    check("wrrd_new", d, 16'h0005);
    wr(3'd1, 16'h0003);
    wait_n(3);
    check("dout_hold", DATA_OUT, 16'h0005);

    // Asynchronous reset with everything pending.
    do_reset();
    wr(3'd2, 16'h003F);
    wr(3'd1, 16'h003F);
    GPIO_IN = 6'h3F;
    wait_n(12);
    rd(3'd4, d);
    check("all_pend", d, 16'h003F);
    check("all_irq", {15'b0, IRQ}, 16'h1);
    RSTb = 1'b0;
    #1;
    check("arst_irq", {15'b0, IRQ}, 16'h0);
    check("arst_vec", {12'b0, IRQ_VEC}, 16'h0);
    check("arst_dout", DATA_OUT, 16'h0);
    cyc();
    RSTb = 1'b1;
    rd(3'd1, d);
    check("arst_enable", d, 16'h0);
    rd(3'd0, d);
    check("arst_filt0", d, 16'h0);
    wait_n(12);
    rd(3'd0, d);
    check("held_high_filt", d, 16'h003F);

    // Reset mid-debounce restarts the full filter delay.
    do_reset();
    GPIO_IN[0] = 1'b1;
    wait_n(5);
    RSTb = 1'b0;
    cyc();
    RSTb = 1'b1;
    wait_n(5);
    rd(3'd0, d);
    check("mid_rst_early", d, 16'h0);
    cyc();
    rd(3'd0, d);
    check("mid_rst_late", d, 16'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
